// File: rtl/dec_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// dec_scan_sequencer_if: control/status bundle between a controller and the scan sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dec_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         chan_mask;
  logic [1:0]         sel;
  logic               en;
  logic               busy;
  logic               frame_done;

  modport master (
    output start, stop, dwell, chan_mask,
    input  sel, en, busy, frame_done
  );

  modport slave (
    input  start, stop, dwell, chan_mask,
    output sel, en, busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/dec_scan_sequencer.sv
// ---------------------------------------------------------------------------
// dec_scan_sequencer: round-robin dwell/blank scanner driving a 2-to-4 decoder {en, in}. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec_scan_sequencer #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  dec_scan_sequencer_if.slave     bus
);

  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [3:0]           mask_q, mask_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic [1:0]           nxt_chan;

  // Next set mask bit strictly above cur, wrapping; returns cur itself for a single-bit mask.
  function automatic logic [1:0] next_chan(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = cur + 2'(k);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    en_d         = en_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    dwell_d      = dwell_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    blank_d      = blank_q;
    nxt_chan     = next_chan(mask_q, sel_q);

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.chan_mask != 4'd0) && (bus.dwell != '0)) begin
          state_d = DWELL;
          dwell_d = bus.dwell;
          mask_d  = bus.chan_mask;
          sel_d   = next_chan(bus.chan_mask, 2'd3);
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = bus.dwell - DWELL_W'(1);
        end
      end

      DWELL: begin
        if (bus.stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          if (BLANK_CYC > 0) begin
            state_d = BLANK;
            en_d    = 1'b0;
            blank_d = BLANK_W'(BLANK_CYC - 1);
          end else begin
            sel_d        = nxt_chan;
            cnt_d        = dwell_q - DWELL_W'(1);
            frame_done_d = (nxt_chan <= sel_q);
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      BLANK: begin
        if (bus.stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (blank_q == '0) begin
          state_d = DWELL;
          sel_d   = nxt_chan;
          en_d    = 1'b1;
          cnt_d   = dwell_q - DWELL_W'(1);
          // Moving to a channel at or below the current one means the scan wrapped.
          frame_done_d = (nxt_chan <= sel_q);
        end else begin
          blank_d = blank_q - BLANK_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dwell_q      <= '0;
      mask_q       <= 4'd0;
      cnt_q        <= '0;
      blank_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      blank_q      <= blank_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: doc/dec_scan_sequencer.md
Name: dec_scan_sequencer

Overview:
Sequential stage that sits directly upstream of the 2-to-4 decoder and drives its {en, in[1:0]} inputs. It scans a set of up to four channels in round-robin order. Each enabled channel's decoder output is held active for a programmable dwell time, followed by a blanking gap with the decoder disabled. Typical uses are multiplexed display digit select and time-sliced peripheral enables.

Parameters:
DWELL_W, 8, width of the dwell-count input; dwell range is 1 to 2^DWELL_W-1 cycles.
BLANK_CYC, 2, number of en-low cycles inserted after each dwell; 0 is legal and means no gap.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  pulse that begins scanning; sampled only in IDLE.
stop  input  1  pulse that aborts scanning; sampled in every state.
dwell  input  DWELL_W  en-high cycles per channel; latched on an accepted start.
chan_mask  input  4  bit i=1 includes channel i in the scan; latched on an accepted start.
sel  output  2  channel index to the decoder in[1:0]; registered.
en  output  1  decoder enable; registered.
busy  output  1  high in any state other than IDLE; registered.
frame_done  output  1  one-cycle pulse marking the start of each repeated frame; registered.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, sel=0, en=0, busy=0, frame_done=0.
  - Latched dwell, latched mask, dwell counter and blank counter are all cleared.
  - Reset asserted mid-scan forces these values immediately, without waiting for a clock edge.
- States: IDLE, DWELL, BLANK. All outputs change only on the rising edge of clk, except on reset.
- IDLE:
  - Start is accepted when start=1, stop=0, chan_mask!=0 and dwell!=0.
  - On the accepting edge: latch dwell and mask; set sel=lowest set bit of mask; set en=1 and busy=1; go to DWELL.
  - Start with mask=0 or dwell=0 is ignored; the block stays in IDLE.
- DWELL:
  - en=1 for exactly the latched dwell cycles, counted from the first en=1 cycle.
  - On the last dwell cycle: if BLANK_CYC>0, go to BLANK with en=0 and sel unchanged.
  - If BLANK_CYC=0, load the next channel directly with en kept at 1.
- BLANK:
  - en=0 for exactly BLANK_CYC cycles; sel holds the previous channel.
  - Then load the next channel and return to DWELL with en=1.
- Next channel: next set bit of the latched mask above the current sel, in ascending order, wrapping 3->0.
  - A single-bit mask reselects the same channel every period.
- frame_done:
  - Pulses high for one cycle, coinciding with the first en=1 cycle of the lowest enabled channel after a wrap.
  - It does not pulse on the initial dwell following start.
- Frame period = popcount(mask) * (dwell + BLANK_CYC) cycles.
- stop=1 in DWELL or BLANK: on the next edge go to IDLE with en=0, busy=0, frame_done=0; sel holds its last value.
- start and stop high together: stop wins. In IDLE the start is ignored; while busy the block goes to IDLE.
- start while busy is ignored. Changes to dwell or chan_mask while busy have no effect until the next accepted start.
- Invariants:
  - sel changes only on an edge where en is 0 before the edge, or on a BLANK_CYC=0 channel switch.
  - en is never 1 for a channel whose latched mask bit is 0.

Test Plan:
1. Reset mid-scan: assert rst_n=0 while en=1 -> en, busy, sel and frame_done read 0 before the next clk edge; the block stays in IDLE after release until a new start.
2. mask=4'b1011, dwell=3, BLANK_CYC=2, start pulse:
   - sel sequence 0,1,3,0,...; each channel has en high 3 cycles, then low 2.
   - frame_done pulses on the first en cycle of the second visit to channel 0, 15 cycles after the first en.
3. mask=4'b0100, dwell=1, BLANK_CYC=0 -> sel stays 2, en stays 1 continuously, frame_done pulses every cycle after the first.
4. start with mask=4'b0000, then start with dwell=0 -> busy stays 0 and en stays 0 in both cases.
5. Scanning with mask=4'b1111, dwell=5:
   - Change mask to 4'b0001 and pulse start mid-scan -> the sequence 0,1,2,3 is unaffected.
   - Pulse stop -> en=0 and busy=0 one edge later; start and stop in the same cycle -> block is in IDLE.
6. Sweep all 15 nonzero masks with dwell=2, over two frames each -> the bench model checks the sel order, the en duty and the frame_done spacing.
